mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port `Memory` block among `NUM_REQ` cache controllers. It accepts one request at a time and drives the memory request bus. For reads it holds `mem_req_valid` until the memory's delayed response arrives; writes complete in one cycle. Each completion is returned to the owning requester. It sits between the per-core cache controllers and `Memory` in the coherence subsystem.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to build the read watchdog (TIMEOUT_CYCLES).
//   state | meaning
//   IDLE  | scanning for the next requester after ptr
//   WRITE | write presented to memory for one cycle
//   READ  | holding the read request until memory responds
//   DONE  | request bus idle for one cycle before the next grant
module mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDRESS_WIDTH  = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              timeout_err,
    output logic                              mem_req_valid,
    output logic                              mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]          mem_req_addr,
    output logic [DATA_WIDTH-1:0]             mem_req_data,
    input  logic                              mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]             mem_resp_data
);
    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mem_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                   state;
    logic [IDW-1:0]           ptr;
    logic [IDW-1:0]           sel_id;
    logic [IDW-1:0]           scan_id;
    logic                     sel_found;
    logic                     sel_write;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Scan starts just past the last grant so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = ptr;
        scan_id   = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_id = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!sel_found && req_valid[scan_id]) begin
                sel_found = 1'b1;
                sel_id    = scan_id;
            end
        end
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_id == IDW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= IDW'(NUM_REQ - 1);
            req_ready     <= '0;
            resp_valid    <= '0;
            resp_data     <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= sel_write;
                        mem_req_addr  <= sel_addr;
                        mem_req_data  <= sel_data;
                        req_ready     <= NUM_REQ'(1) << sel_id;
                        grant_id      <= sel_id;
                        ptr           <= sel_id;
                        busy          <= 1'b1;
                        state         <= sel_write ? WRITE : READ;
`ifdef MEM_ARB_TIMEOUT_EN
                        to_cnt        <= TW'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                WRITE: begin
                    mem_req_valid <= 1'b0;
                    resp_valid    <= NUM_REQ'(1) << grant_id;
                    state         <= DONE;
                end
                READ: begin
                    if (mem_resp_valid) begin
                        resp_data     <= mem_resp_data;
                        resp_valid    <= NUM_REQ'(1) << grant_id;
                        mem_req_valid <= 1'b0;
                        state         <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        resp_data     <= '0;
                        resp_valid    <= NUM_REQ'(1) << grant_id;
                        mem_req_valid <= 1'b0;
                        timeout_q     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter against a 4-cycle read-latency memory model.
// Build with MEM_ARB_TIMEOUT_EN to exercise the watchdog at TIMEOUT_CYCLES=8.
module tb_mem_arbiter;
    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 15;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready, resp_valid;
    logic [DW-1:0]     resp_data;
    logic [1:0]        grant_id;
    logic              busy, timeout_err;
    logic              mem_req_valid, mem_req_write;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic              mem_resp_valid;
    logic [DW-1:0]     mem_resp_data;

    mem_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Memory model: reset contents addr*10, read response asserted 4 edges after request.
    logic [DW-1:0] store [64];
    logic [63:0]   written = '0;
    logic [2:0]    dcnt = '0;
    logic          mem_rv = 1'b0;
    logic [DW-1:0] mem_rd = '0;
    logic          spur = 1'b0;
    logic          mute = 1'b0;

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_write) begin
            store[mem_req_addr]   <= mem_req_data;
            written[mem_req_addr] <= 1'b1;
        end
        if (mem_req_valid && !mem_req_write) begin
            mem_rv <= (dcnt == 3'd3);
            if (dcnt == 3'd3)
                mem_rd <= written[mem_req_addr] ? store[mem_req_addr] : DW'(int'(mem_req_addr) * 10);
            dcnt <= dcnt + 3'd1;
        end else begin
            dcnt   <= '0;
            mem_rv <= 1'b0;
        end
    end

    assign mem_resp_valid = (mem_rv && !mute) || spur;
    assign mem_resp_data  = spur ? 32'h0BAD_0BAD : mem_rd;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event not expected or never seen", name);
    endtask

    typedef struct {
        int            id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } gnt_t;
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          chk_data;
        logic          tmo;
        int            lat;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t g;
    rsp_t r;
    int   last_rdy[NR];

    task automatic exp_grant(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gq.push_back('{id: id, wr: wr, addr: a, data: d});
    endtask

    task automatic exp_resp(input int id, input logic [DW-1:0] d, input logic chk, input logic tmo, input int lat);
        rq.push_back('{id: id, data: d, chk_data: chk, tmo: tmo, lat: lat});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (req_ready != '0) begin
                if (gq.size() == 0) flag("unexpected_grant");
                else begin
                    g = gq.pop_front();
                    check("grant_onehot", 64'(req_ready), 64'(1) << g.id);
                    check("grant_id", 64'(grant_id), 64'(g.id));
                    check("mem_req_valid_at_grant", 64'(mem_req_valid), 64'd1);
                    check("mem_req_addr", 64'(mem_req_addr), 64'(g.addr));
                    check("mem_req_write", 64'(mem_req_write), 64'(g.wr));
                    if (g.wr) check("mem_req_data", 64'(mem_req_data), 64'(g.data));
                    last_rdy[g.id] = cyc;
                end
            end
            if (resp_valid != '0) begin
                if (rq.size() == 0) flag("unexpected_resp");
                else begin
                    r = rq.pop_front();
                    check("resp_onehot", 64'(resp_valid), 64'(1) << r.id);
                    check("resp_latency", 64'(cyc - last_rdy[r.id]), 64'(r.lat));
                    check("timeout_err", 64'(timeout_err), 64'(r.tmo));
                    check("mem_req_valid_at_resp", 64'(mem_req_valid), 64'd0);
                    if (r.chk_data) check("resp_data", 64'(resp_data), 64'(r.data));
                end
            end else if (timeout_err) begin
                flag("timeout_err_without_resp");
            end
        end
    end

    task automatic set_req(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_addr[id*AW +: AW] = a;
        req_data[id*DW +: DW] = d;
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            req_valid = req_valid & ~req_ready;
            if (req_valid == '0 && !busy && gq.size() == 0 && rq.size() == 0) done = 1;
        end
        if (!done) flag("drain_timeout");
    endtask

    task automatic wait_ready(input int id, output int c);
        c = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) flag("wait_ready_timeout");
    endtask

    function automatic logic [19:0] ctrl_bus();
        return {req_ready, resp_valid, grant_id, busy, timeout_err, mem_req_valid, mem_req_write, mem_req_addr};
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0, c1;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'(ctrl_bus()), 64'd0);
        check("reset_data", {resp_data, mem_req_data}, 64'd0);
        reset = 1'b0;

        // Requester 0 reads addr 5 first after reset.
        @(negedge clk);
        set_req(0, 1'b0, 6'd5, '0);
        exp_grant(0, 1'b0, 6'd5, '0);
        exp_resp(0, 32'd50, 1'b1, 1'b0, 5);
        drain(100);

        // Spurious memory response while idle.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        check("spur_idle_ctrl", 64'(ctrl_bus()), 64'(20'd5));
        check("spur_idle_data", 64'(resp_data), 64'd50);

        // Write 0xDEAD then read back; spurious response during WRITE.
        set_req(1, 1'b1, 6'd3, 32'hDEAD);
        exp_grant(1, 1'b1, 6'd3, 32'hDEAD);
        exp_resp(1, '0, 1'b0, 1'b0, 1);
        wait_ready(1, c0);
        req_write[1] = 1'b0;
        exp_grant(1, 1'b0, 6'd3, '0);
        exp_resp(1, 32'hDEAD, 1'b1, 1'b0, 5);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur_write_resp_data", 64'(resp_data), 64'd50);
        wait_ready(1, c1);
        req_valid[1] = 1'b0;
        check("wr_rd_accept_gap", 64'(c1 - c0), 64'd3);
        drain(100);

        // All four request together after reset, then 0 and 2 again.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b0, AW'(10 + i), '0);
            exp_grant(i, 1'b0, AW'(10 + i), '0);
            exp_resp(i, DW'(100 + 10 * i), 1'b1, 1'b0, 5);
        end
        drain(300);
        set_req(0, 1'b0, 6'd20, '0);
        set_req(2, 1'b0, 6'd22, '0);
        exp_grant(0, 1'b0, 6'd20, '0);
        exp_resp(0, 32'd200, 1'b1, 1'b0, 5);
        exp_grant(2, 1'b0, 6'd22, '0);
        exp_resp(2, 32'd220, 1'b1, 1'b0, 5);
        drain(200);

        // Reset in the middle of a read; the read is dropped.
        set_req(1, 1'b0, 6'd7, '0);
        exp_grant(1, 1'b0, 6'd7, '0);
        wait_ready(1, c0);
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midread_reset_ctrl", 64'(ctrl_bus()), 64'd0);
        check("midread_reset_data", {resp_data, mem_req_data}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        set_req(2, 1'b0, 6'd4, '0);
        set_req(0, 1'b0, 6'd6, '0);
        exp_grant(0, 1'b0, 6'd6, '0);
        exp_resp(0, 32'd60, 1'b1, 1'b0, 5);
        exp_grant(2, 1'b0, 6'd4, '0);
        exp_resp(2, 32'd40, 1'b1, 1'b0, 5);
        drain(200);

        // Memory never answers.
        mute = 1'b1;
        set_req(3, 1'b0, 6'd9, '0);
        exp_grant(3, 1'b0, 6'd9, '0);
`ifdef MEM_ARB_TIMEOUT_EN
        exp_resp(3, 32'd0, 1'b1, 1'b1, TO);
        drain(100);
`else
        wait_ready(3, c0);
        req_valid[3] = 1'b0;
        repeat (40) @(negedge clk);
        check("read_wait_busy", 64'({busy, mem_req_valid}), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        mute = 1'b0;
        repeat (3) @(negedge clk);
        check("queues_empty", 64'(gq.size() + rq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
